man_link_ctrl: RTL

MAN_LINK_CTRL -- requirements
Module: man_link_ctrl

---
 rtl/man_link_pkg.sv | 19 +
 rtl/man_link_fifo.sv | 60 ++++++
 rtl/man_link_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/man_link_pkg.sv
// man_link_pkg: shared types and constants for the SPI-to-Manchester link controller.
package man_link_pkg;

    localparam int unsigned DATA_W = 16;

    // Word returned to the SPI host when a transaction fails.
    localparam logic [DATA_W-1:0] ERR_WORD_DEF = 16'hFFFF;

    // Cycles the encoder is given to raise enc_busy after enc_start.
    localparam int unsigned ENC_RISE_CYC = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ENC,
        WAIT_RESP
    } state_e;

endpackage

// File: rtl/man_link_fifo.sv
// man_link_fifo: synchronous command queue with push/pop/full/empty/level.
// A push while full is taken only when a pop happens on the same edge.
module man_link_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [4:0]   level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [4:0]    level_q, level_d;
    logic          do_push, do_pop;

    assign empty_o = (level_q == 5'd0);
    assign full_o  = (level_q == 5'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy next-state
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop)
            level_d = level_q + 5'd1;
        else if (!do_push && do_pop)
            level_d = level_q - 5'd1;
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= 5'd0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage array, no reset needed: contents are only read when level is non-zero
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/man_link_ctrl.sv
// man_link_ctrl: queues SPI command words, sends each through the Manchester
// encoder, waits for the decoded response and hands it back for the next SPI frame.
// Optional feature: define MAN_LINK_RETRY_EN to re-issue a timed-out command once.
module man_link_ctrl
    import man_link_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       TIMEOUT_CYC = 2400,
    parameter logic [DATA_W-1:0] ERR_WORD    = ERR_WORD_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              spi_rx_flag,
    input  logic [DATA_W-1:0] spi_rx_data,
    output logic              enc_start,
    output logic [DATA_W-1:0] enc_data,
    input  logic              enc_busy,
    input  logic              dec_valid,
    input  logic [DATA_W-1:0] dec_data,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic              busy,
    output logic [4:0]        fifo_level,
    output logic              overflow_err,
    output logic              timeout_err
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(ENC_RISE_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rise_q, rise_d;
    logic              enc_start_q, enc_start_d;
    logic [DATA_W-1:0] enc_data_q, enc_data_d;
    logic [DATA_W-1:0] spi_tx_q, spi_tx_d;
    logic              ovf_q, to_q, to_d;

    logic              fifo_full, fifo_empty, pop, drop;
    logic [DATA_W-1:0] fifo_head;
    logic              to_evt, retry_go, reissue;

    man_link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst     (rst),
        .push_i  (spi_rx_flag),
        .pop_i   (pop),
        .wdata_i (spi_rx_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign drop = spi_rx_flag && fifo_full && !pop;

    // A timeout is either the encoder never starting or the response never arriving;
    // a response landing on the final cycle takes priority.
    assign to_evt = ((state_q == WAIT_ENC) && !rise_q && !enc_busy && (cnt_q == RISE_LAST))
                 || ((state_q == WAIT_RESP) && !dec_valid && (cnt_q == RESP_LAST));

`ifdef MAN_LINK_RETRY_EN
    logic retry_q, retry_d;

    // First timeout of a command re-issues the held word; the second one fails it
    assign retry_go = to_evt && !retry_q;
    assign reissue  = retry_q;

    // Per-command retry marker, cleared whenever the FSM is back in IDLE
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) retry_q <= 1'b0;
        else      retry_q <= retry_d;
    end

    // Retry marker next-state
    always_comb begin
        retry_d = retry_q;
        if (state_q == IDLE) retry_d = 1'b0;
        else if (retry_go)   retry_d = 1'b1;
    end
`else
    assign retry_go = 1'b0;
    assign reissue  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!fifo_empty && !enc_busy) state_d = ISSUE;
            ISSUE:     state_d = WAIT_ENC;
            WAIT_ENC: begin
                if (to_evt)                  state_d = retry_go ? ISSUE : IDLE;
                else if (rise_q && !enc_busy) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (dec_valid)   state_d = IDLE;
                else if (to_evt) state_d = retry_go ? ISSUE : IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // FSM output logic: queue pop, encoder handoff, counter and response capture
    always_comb begin
        pop         = 1'b0;
        enc_start_d = 1'b0;
        enc_data_d  = enc_data_q;
        spi_tx_d    = spi_tx_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        rise_d      = rise_q;
        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                enc_start_d = 1'b1;
                cnt_d       = '0;
                rise_d      = 1'b0;
                // A retry resends the word still held in enc_data
                if (!reissue) begin
                    pop        = 1'b1;
                    enc_data_d = fifo_head;
                end
            end
            WAIT_ENC: begin
                if (!rise_q) begin
                    if (enc_busy)     rise_d = 1'b1;
                    else if (!to_evt) cnt_d  = cnt_q + CNT_W'(1);
                end else if (!enc_busy) begin
                    cnt_d = '0;
                end
            end
            WAIT_RESP: begin
                if (dec_valid)    spi_tx_d = dec_data;
                else if (!to_evt) cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
        if (to_evt && !retry_go) begin
            spi_tx_d = ERR_WORD;
            to_d     = 1'b1;
        end
    end

    // Datapath and sticky error registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rise_q      <= 1'b0;
            enc_start_q <= 1'b0;
            enc_data_q  <= '0;
            spi_tx_q    <= '0;
            ovf_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rise_q      <= rise_d;
            enc_start_q <= enc_start_d;
            enc_data_q  <= enc_data_d;
            spi_tx_q    <= spi_tx_d;
            ovf_q       <= ovf_q | drop;
            to_q        <= to_d;
        end
    end

    assign enc_start    = enc_start_q;
    assign enc_data     = enc_data_q;
    assign spi_tx_data  = spi_tx_q;
    assign overflow_err = ovf_q;
    assign timeout_err  = to_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
